sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 15 +
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared defines for the SRAM arbiter (bus widths, FSM encoding, grant ids)
package sram_arbiter_pkg;
   localparam logic ENABLE        = 1'b1;
   localparam logic DISABLE       = 1'b0;
   localparam logic RST_ENABLE    = 1'b1;
   localparam int   INST_ADDR_BUS = 16;
   localparam int   REG_BUS       = 16;
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_ACCESS  = 2'b01,
      ARB_RECOVER = 2'b10
   } arb_state_e;
   localparam logic GRANT_IF  = 1'b0;
   localparam logic GRANT_MEM = 1'b1;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one external SRAM between fetch and MEM ports, MEM first, fixed-length strobes
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W        = INST_ADDR_BUS,
   parameter int DATA_W        = REG_BUS,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic              mem_ack_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   output logic              stallreq_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic              sram_ce_n_o,
   output logic              sram_oe_n_o,
   output logic              sram_we_n_o,
   output logic [DATA_W-1:0] sram_wdata_o,
   output logic              sram_data_oe_o,
   input  logic [DATA_W-1:0] sram_rdata_i
);
   arb_state_e state;
   logic [3:0] cnt;
   logic       grant;
   logic       we;
   logic       last;
   logic       new_we;
   assign last       = cnt == 4'(ACCESS_CYCLES - 1);
   assign new_we     = mem_req_i & mem_we_i;
   assign stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state          <= ARB_IDLE;
         cnt            <= '0;
         grant          <= GRANT_IF;
         we             <= DISABLE;
         sram_addr_o    <= '0;
         sram_wdata_o   <= '0;
         sram_ce_n_o    <= 1'b1;
         sram_oe_n_o    <= 1'b1;
         sram_we_n_o    <= 1'b1;
         sram_data_oe_o <= DISABLE;
         if_ack_o       <= DISABLE;
         mem_ack_o      <= DISABLE;
         if_data_o      <= '0;
         mem_rdata_o    <= '0;
      end else begin
         case (state)
            ARB_IDLE: if (mem_req_i | if_req_i) begin
               grant          <= mem_req_i ? GRANT_MEM : GRANT_IF;
               we             <= new_we;
               sram_addr_o    <= mem_req_i ? mem_addr_i : if_addr_i;
               sram_wdata_o   <= mem_wdata_i;
               cnt            <= '0;
               sram_ce_n_o    <= 1'b0;
               sram_oe_n_o    <= new_we;
               sram_we_n_o    <= ~new_we;
               sram_data_oe_o <= new_we;
               state          <= ARB_ACCESS;
            end
            ARB_ACCESS: begin
               cnt <= cnt + 4'd1;
               if (last) begin
                  if (!we && grant == GRANT_IF) if_data_o <= sram_rdata_i;
                  if (!we && grant == GRANT_MEM) mem_rdata_o <= sram_rdata_i;
                  if_ack_o    <= grant == GRANT_IF;
                  mem_ack_o   <= grant == GRANT_MEM;
                  sram_ce_n_o <= 1'b1;
                  sram_oe_n_o <= 1'b1;
                  sram_we_n_o <= 1'b1;
                  state       <= ARB_RECOVER;
               end
            end
            // write data keeps driving the pad through RECOVER for hold after we_n rises
            ARB_RECOVER: begin
               if_ack_o       <= DISABLE;
               mem_ack_o      <= DISABLE;
               sram_data_oe_o <= DISABLE;
               state          <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vectors, corner sequences and a randomized transaction-level model check
module tb_sram_arbiter;
   localparam int AC = 2;
   logic        clk, rst;
   logic        if_req, if_ack, mem_req, mem_we, mem_ack, stallreq;
   logic [15:0] if_addr, if_data, mem_addr, mem_wdata, mem_rdata;
   logic [15:0] sram_addr, sram_wdata, sram_rdata;
   logic        ce_n, oe_n, we_n, data_oe;
   logic        pad_force;
   logic [15:0] pad_val;
   logic [15:0] smem [256];
   logic [15:0] ref_mem [256];
   int          pass = 0, total = 0;

   logic [1:0]  xreq, xack, xstall, xmack, xce, xoe, xwe, xdoe;
   logic [15:0] xaddr_o [2], xdata [2], xmrd [2], xwd [2], xrd [2];

   sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_data_o(if_data),
      .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_ack_o(mem_ack), .mem_rdata_o(mem_rdata), .stallreq_o(stallreq),
      .sram_addr_o(sram_addr), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n),
      .sram_wdata_o(sram_wdata), .sram_data_oe_o(data_oe), .sram_rdata_i(sram_rdata)
   );

   for (genvar g = 0; g < 2; g++) begin : gx
      sram_arbiter #(.ACCESS_CYCLES(g ? 15 : 1)) ux (
         .clk(clk), .rst(rst),
         .if_req_i(xreq[g]), .if_addr_i(16'h0100), .if_ack_o(xack[g]), .if_data_o(xdata[g]),
         .mem_req_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(16'h0000), .mem_wdata_i(16'h0000),
         .mem_ack_o(xmack[g]), .mem_rdata_o(xmrd[g]), .stallreq_o(xstall[g]),
         .sram_addr_o(xaddr_o[g]), .sram_ce_n_o(xce[g]), .sram_oe_n_o(xoe[g]), .sram_we_n_o(xwe[g]),
         .sram_wdata_o(xwd[g]), .sram_data_oe_o(xdoe[g]), .sram_rdata_i(xrd[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [15:0] init_word(input logic [7:0] a);
      return {a, ~a};
   endfunction

   // behavioural SRAM on the pad
   assign sram_rdata = pad_force ? pad_val : smem[sram_addr[7:0]];
   always @(posedge clk)
      if (rst) for (int i = 0; i < 256; i++) smem[i] <= init_word(8'(i));
      else if (!ce_n && !we_n) smem[sram_addr[7:0]] <= sram_wdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else pass++;
   endtask

   task automatic txn(input logic m, input logic w, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] p, output int lat, output int oel, output int wel,
                      output int doel, output logic [15:0] q, output logic ok);
      lat = 0; oel = 0; wel = 0; doel = 0; ok = 1'b1;
      pad_force = 1'b1; pad_val = p;
      if (m) begin mem_req = 1'b1; mem_we = w; mem_addr = a; mem_wdata = d; end
      else begin if_req = 1'b1; if_addr = a; end
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         oel += int'(!oe_n); wel += int'(!we_n); doel += int'(data_oe);
         if (!ce_n && (sram_addr !== a || (m && w && sram_wdata !== d))) ok = 1'b0;
         if (m ? mem_ack : if_ack) begin
            if (stallreq) ok = 1'b0;
            break;
         end
         if (!stallreq || if_ack || mem_ack) ok = 1'b0;
      end
      q = m ? mem_rdata : if_data;
      mem_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        m, w;
      logic [15:0] a, d, p, q;
      int          oel, wel, doel;
   } vec_t;

   initial begin
      vec_t vt[5];
      int lat, oel, wel, doel, n, ma, ia, acks, cel, last, nf, sf, st, k;
      logic [15:0] q, eq_if, eq_mem;
      logic ok, both;
      vt[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h4A20, 16'h4A20, 2, 0, 0};
      vt[1] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234, 16'h1234, 2, 0, 0};
      vt[2] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h5555, 16'h1234, 0, 2, 3};
      vt[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hC3C3, 16'hC3C3, 2, 0, 0};
      vt[4] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 2, 0, 0};
      rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
      pad_force = 1'b1; pad_val = 16'h0000; xreq = 2'b00;
      xrd[0] = 16'h5A01; xrd[1] = 16'h5A0F;
      repeat (2) @(negedge clk);
      chk("reset_strobes", {ce_n, oe_n, we_n, data_oe}, 4'b1110);
      chk("reset_acks", {if_ack, mem_ack, stallreq}, 3'b000);
      chk("reset_data", {if_data, mem_rdata}, 32'h0);
      chk("reset_addr_wdata", {sram_addr, sram_wdata}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         txn(vt[i].m, vt[i].w, vt[i].a, vt[i].d, vt[i].p, lat, oel, wel, doel, q, ok);
         chk($sformatf("vec%0d_latency", i), lat, AC + 1);
         chk($sformatf("vec%0d_oe_cycles", i), oel, vt[i].oel);
         chk($sformatf("vec%0d_we_cycles", i), wel, vt[i].wel);
         chk($sformatf("vec%0d_doe_cycles", i), doel, vt[i].doel);
         chk($sformatf("vec%0d_data", i), q, vt[i].q);
         chk($sformatf("vec%0d_addr_stall", i), ok, 1'b1);
      end

      // simultaneous requests: MEM first, IF at the following IDLE edge
      pad_force = 1'b1; pad_val = 16'h1234;
      if_req = 1'b1; if_addr = 16'h0040; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h8000;
      n = 0; ma = -1; ia = -1; both = 1'b0;
      while (n < 40 && ia < 0) begin
         @(negedge clk);
         n++;
         if (if_ack && mem_ack) both = 1'b1;
         if (mem_ack) begin
            ma = n;
            chk("simul_mem_data", mem_rdata, 16'h1234);
            mem_req = 1'b0; pad_val = 16'h0BAD;
         end
         if (if_ack) begin
            ia = n;
            chk("simul_if_data", if_data, 16'h0BAD);
            if_req = 1'b0;
         end
      end
      chk("simul_mem_latency", ma, AC + 1);
      chk("simul_if_latency", ia, 2 * AC + 3);
      chk("simul_acks_overlap", both, 1'b0);
      @(negedge clk);

      // fetch held high across three addresses
      pad_force = 1'b0; if_req = 1'b1; if_addr = 16'h0011;
      n = 0; acks = 0; cel = 0; last = 0;
      while (n < 60 && acks < 3) begin
         @(negedge clk);
         n++;
         cel += int'(!ce_n);
         if (if_ack) begin
            chk("held_data", if_data, init_word(if_addr[7:0]));
            if (acks == 0) chk("held_first_latency", n, AC + 1);
            else chk("held_spacing", n - last, AC + 2);
            if (!ce_n) cel += 100;
            last = n; acks++;
            if_addr = if_addr + 16'd1;
         end
      end
      if_req = 1'b0;
      chk("held_ack_count", acks, 3);
      chk("held_ce_cycles", cel, 3 * AC);
      @(negedge clk);

      // reset in the second ACCESS cycle of a write
      pad_force = 1'b1; pad_val = 16'h7777;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0300; mem_wdata = 16'h1111;
      @(negedge clk);
      chk("rst_pre_we", we_n, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_strobes", {ce_n, oe_n, we_n, data_oe}, 4'b1110);
      chk("rst_mid_addr_wdata", {sram_addr, sram_wdata}, 32'h0);
      chk("rst_mid_data_acks", {if_data, mem_rdata, if_ack, mem_ack}, 34'h0);
      mem_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         n += int'(mem_ack) + int'(if_ack);
      end
      chk("rst_no_ack", n, 0);
      txn(1'b1, 1'b0, 16'h0300, 16'h0000, 16'h7777, lat, oel, wel, doel, q, ok);
      chk("rst_after_latency", lat, AC + 1);
      chk("rst_after_data", q, 16'h7777);

      // ACCESS_CYCLES = 1 and 15
      for (int g = 0; g < 2; g++) begin
         int ac;
         ac = g ? 15 : 1;
         n = 0; oel = 0;
         xreq[g] = 1'b1;
         while (n < 40) begin
            @(negedge clk);
            n++;
            oel += int'(!xoe[g]);
            if (xack[g]) break;
         end
         xreq[g] = 1'b0;
         chk($sformatf("ac%0d_latency", ac), n, ac + 1);
         chk($sformatf("ac%0d_oe_cycles", ac), oel, ac);
         chk($sformatf("ac%0d_data", ac), xdata[g], xrd[g]);
         @(negedge clk);
      end

      // randomized traffic against a cycle-level transaction model
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; pad_force = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
      nf = 0; ia = -1; ma = -1; sf = -1; st = -2; eq_if = 16'h0; eq_mem = 16'h0;
      for (int c = 0; c < 400; c++) begin
         chk("rnd_if_ack", if_ack, c == ia);
         chk("rnd_mem_ack", mem_ack, c == ma);
         chk("rnd_ce", ce_n, !(c >= sf && c <= st));
         chk("rnd_stall", stallreq, (if_req && c != ia) || (mem_req && c != ma));
         if (c == ia) chk("rnd_if_data", if_data, eq_if);
         if (c == ma) chk("rnd_mem_data", mem_rdata, eq_mem);
         if (c == ia || !if_req) begin
            if_req = $urandom_range(0, 1) == 0;
            if_addr = 16'($urandom_range(0, 31));
         end
         if (c == ma || !mem_req) begin
            mem_req = $urandom_range(0, 3) == 0;
            mem_we = 1'($urandom_range(0, 1));
            mem_addr = 16'($urandom_range(0, 31));
            mem_wdata = 16'($urandom);
         end
         if (c + 1 >= nf && (mem_req || if_req)) begin
            k = c + 1; sf = k; st = k + AC - 1; nf = k + AC + 2;
            if (mem_req) begin
               ma = k + AC;
               if (mem_we) ref_mem[mem_addr[7:0]] = mem_wdata;
               else eq_mem = ref_mem[mem_addr[7:0]];
            end else begin
               ia = k + AC;
               eq_if = ref_mem[if_addr[7:0]];
            end
         end
         @(negedge clk);
      end
      if_req = 1'b0; mem_req = 1'b0;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
